// File: rtl/retire_perf_mon.sv
// retire_perf_mon: windowed cycle / retired-instruction counters with
// watchdog, saturation and a coherent 32-bit register read port.
module retire_perf_mon #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned CNT_W     = 48,
  parameter int unsigned TIMEOUT   = 200000,
  parameter int unsigned TMO_W     = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_LANES-1:0] retire_valid_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 clear_i,
  input  logic                 rd_req_i,
  input  logic [2:0]           rd_addr_i,
  output logic                 rd_ack_o,
  output logic [31:0]          rd_data_o,
  output logic [1:0]           state_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic                 overflow_o
);

  localparam int unsigned HI_W = CNT_W - 32;
  localparam int unsigned SW   = CNT_W + 1;
  localparam logic [TMO_W-1:0] WD_LAST =
    TMO_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  localparam logic [31:0] TMO_WORD = 32'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_TMO  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cycle_cnt, instr_cnt;
  logic [TMO_W-1:0]  wdog;
  logic [HI_W-1:0]   cycle_shadow, instr_shadow;
  logic              overflow_q;
  logic [2:0]        retired;
  logic [SW-1:0]     cycle_sum, instr_sum;
  logic              wd_fire;
  logic [31:0]       cyc_hi, ins_hi, rd_word;

  always_comb begin
    retired = '0;
    for (int i = 0; i < int'(NUM_LANES); i++)
      retired = retired + 3'(retire_valid_i[i]);
  end

  // one extra bit catches the carry out for saturation
  assign cycle_sum = {1'b0, cycle_cnt} + SW'(1);
  assign instr_sum = {1'b0, instr_cnt} + SW'(retired);
  assign wd_fire   = (TIMEOUT != 0) && (wdog == WD_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i)
      state_d = S_IDLE;
    else if (start_i)
      state_d = S_RUN;
    else if (state_q == S_RUN) begin
      if (stop_i)       state_d = S_DONE;
      else if (wd_fire) state_d = S_TMO;
    end
  end

  always_comb begin
    state_o   = state_q;
    done_o    = (state_q == S_DONE);
    timeout_o = (state_q == S_TMO);
  end

  assign overflow_o = overflow_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
      wdog       <= '0;
      overflow_q <= 1'b0;
    end else if (clear_i || start_i) begin
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
      wdog       <= '0;
      overflow_q <= 1'b0;
    end else if (state_q == S_RUN) begin
      wdog       <= wdog + TMO_W'(1);
      cycle_cnt  <= cycle_sum[CNT_W] ? '1 : cycle_sum[CNT_W-1:0];
      instr_cnt  <= instr_sum[CNT_W] ? '1 : instr_sum[CNT_W-1:0];
      overflow_q <= overflow_q | cycle_sum[CNT_W] | instr_sum[CNT_W];
    end
  end

  // low-word reads snapshot the high part for a coherent follow-up read
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_shadow <= '0;
      instr_shadow <= '0;
    end else if (clear_i) begin
      cycle_shadow <= '0;
      instr_shadow <= '0;
    end else if (rd_req_i) begin
      if (rd_addr_i == 3'd0) cycle_shadow <= cycle_cnt[CNT_W-1:32];
      if (rd_addr_i == 3'd2) instr_shadow <= instr_cnt[CNT_W-1:32];
    end
  end

  always_comb begin
    cyc_hi = '0;
    ins_hi = '0;
    cyc_hi[HI_W-1:0] = cycle_shadow;
    ins_hi[HI_W-1:0] = instr_shadow;
    rd_word = '0;
    unique case (rd_addr_i)
      3'd0:    rd_word = cycle_cnt[31:0];
      3'd1:    rd_word = cyc_hi;
      3'd2:    rd_word = instr_cnt[31:0];
      3'd3:    rd_word = ins_hi;
      3'd4:    rd_word = {27'b0, overflow_q, timeout_o, done_o, state_o};
      3'd5:    rd_word = TMO_WORD;
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ack_o  <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_ack_o <= rd_req_i;
      if (rd_req_i) rd_data_o <= rd_word;
    end
  end

endmodule

// File: tb/tb_retire_perf_mon.sv
// tb_retire_perf_mon: scenario tasks plus randomized windows checked
// against a count-based model of the monitor.
module tb_retire_perf_mon;

  localparam int  CW   = 33;
  localparam int  TMO  = 100;
  localparam longint MAXV = (64'd1 << CW) - 1;

  logic        clk, rst_n;
  logic [1:0]  rv;
  logic        start, stop, clr, req;
  logic [2:0]  addr;
  logic        ack;
  logic [31:0] data;
  logic [1:0]  st;
  logic        done, tmo, ovf;

  int checks = 0;
  int failures = 0;

  retire_perf_mon #(
    .NUM_LANES(2),
    .CNT_W(CW),
    .TIMEOUT(TMO),
    .TMO_W(32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .retire_valid_i(rv),
    .start_i(start),
    .stop_i(stop),
    .clear_i(clr),
    .rd_req_i(req),
    .rd_addr_i(addr),
    .rd_ack_o(ack),
    .rd_data_o(data),
    .state_o(st),
    .done_o(done),
    .timeout_o(tmo),
    .overflow_o(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] a, output logic k,
                    output logic [31:0] d);
    req = 1'b1;
    addr = a;
    @(negedge clk);
    k = ack;
    d = data;
    req = 1'b0;
  endtask

  task automatic open_window();
    start = 1'b1;
    rv = 2'b11;
    tick();
    start = 1'b0;
    rv = 2'b00;
  endtask

  task automatic test_reset();
    logic k;
    logic [31:0] d;
    rst_n = 1'b1;
    {start, stop, clr, req} = '0;
    rv = '0;
    addr = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (st !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", st); end
    checks++; if ({done, tmo, ovf} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {done, tmo, ovf}); end
    checks++; if (ack !== 1'b0 || data !== 32'd0) begin failures++; $display("FAIL rst_rd got ack=%b data=%0h exp 0/0", ack, data); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    rd(3'd0, k, d);
    checks++; if (k !== 1'b1 || d !== 32'd0) begin failures++; $display("FAIL rst_cycle got ack=%b data=%0h exp 1/0", k, d); end
    rd(3'd5, k, d);
    checks++; if (d !== 32'd100) begin failures++; $display("FAIL rst_tmo_reg got=%0d exp=100", d); end
    rd(3'd6, k, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL rst_addr6 got=%0h exp=0", d); end
  endtask

  task automatic test_basic();
    logic k;
    logic [31:0] d;
    open_window();
    for (int i = 1; i <= 10; i++) begin
      rv = 2'b11;
      stop = (i == 10);
      tick();
    end
    stop = 1'b0;
    rv = 2'b00;
    checks++; if (st !== 2'd2 || done !== 1'b1 || tmo !== 1'b0) begin failures++; $display("FAIL basic_state got st=%0d done=%b tmo=%b exp 2/1/0", st, done, tmo); end
    rd(3'd4, k, d);
    checks++; if (k !== 1'b1 || d !== 32'h6) begin failures++; $display("FAIL basic_status got ack=%b data=%0h exp 1/6", k, d); end
    rd(3'd0, k, d);
    checks++; if (d !== 32'd10) begin failures++; $display("FAIL basic_cycles got=%0d exp=10", d); end
    rd(3'd2, k, d);
    checks++; if (d !== 32'd20) begin failures++; $display("FAIL basic_instr got=%0d exp=20", d); end
    rd(3'd1, k, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL basic_cyc_hi got=%0h exp=0", d); end
  endtask

  task automatic test_lanes();
    logic k;
    logic [31:0] d;
    logic [1:0] pat [4];
    int ei;
    pat = '{2'b01, 2'b10, 2'b00, 2'b11};
    ei = 0;
    open_window();
    for (int i = 0; i < 8; i++) begin
      rv = pat[i % 4];
      ei += $countones(rv);
      stop = (i == 7);
      tick();
    end
    stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rv = 2'b11;
      stop = (i == 2);
      tick();
    end
    stop = 1'b0;
    rv = 2'b00;
    rd(3'd0, k, d);
    checks++; if (d !== 32'd8) begin failures++; $display("FAIL lanes_cycles got=%0d exp=8", d); end
    rd(3'd2, k, d);
    checks++; if (d !== 32'(ei)) begin failures++; $display("FAIL lanes_instr got=%0d exp=%0d", d, ei); end
    checks++; if (st !== 2'd2) begin failures++; $display("FAIL lanes_state got=%0d exp=2", st); end
  endtask

  task automatic test_restart();
    logic k;
    logic [31:0] d;
    open_window();
    for (int i = 0; i < 5; i++) begin
      rv = 2'b11;
      tick();
    end
    start = 1'b1;
    rv = 2'b11;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      rv = 2'b01;
      stop = (i == 3);
      tick();
    end
    stop = 1'b0;
    rv = 2'b00;
    rd(3'd0, k, d);
    checks++; if (d !== 32'd3) begin failures++; $display("FAIL restart_cycles got=%0d exp=3", d); end
    rd(3'd2, k, d);
    checks++; if (d !== 32'd3) begin failures++; $display("FAIL restart_instr got=%0d exp=3", d); end
  endtask

  task automatic test_timeout();
    logic k;
    logic [31:0] d;
    int n;
    bit seen;
    open_window();
    n = 0;
    seen = 0;
    while (!seen && n < 150) begin
      rv = 2'($urandom);
      tick();
      n++;
      if (tmo === 1'b1) seen = 1;
    end
    rv = 2'b00;
    checks++; if (!seen || n != TMO) begin failures++; $display("FAIL tmo_latency got seen=%0d n=%0d exp n=%0d", seen, n, TMO); end
    checks++; if (st !== 2'd3 || done !== 1'b0) begin failures++; $display("FAIL tmo_state got st=%0d done=%b exp 3/0", st, done); end
    rd(3'd0, k, d);
    checks++; if (d !== 32'(TMO)) begin failures++; $display("FAIL tmo_cycles got=%0d exp=%0d", d, TMO); end
    rd(3'd4, k, d);
    checks++; if (d !== 32'h0B) begin failures++; $display("FAIL tmo_status got=%0h exp=b", d); end
    open_window();
    for (int i = 1; i <= TMO; i++) begin
      rv = 2'b10;
      stop = (i == TMO);
      tick();
    end
    stop = 1'b0;
    rv = 2'b00;
    checks++; if (st !== 2'd2 || tmo !== 1'b0) begin failures++; $display("FAIL tmo_stop_wins got st=%0d tmo=%b exp 2/0", st, tmo); end
    rd(3'd0, k, d);
    checks++; if (d !== 32'(TMO)) begin failures++; $display("FAIL tmo_stop_cycles got=%0d exp=%0d", d, TMO); end
  endtask

  task automatic test_carry();
    open_window();
    tick();
    tick();
    force dut.cycle_cnt = 33'h0_FFFF_FFFF;
    #1 release dut.cycle_cnt;
    req = 1'b1;
    addr = 3'd0;
    tick();
    checks++; if (ack !== 1'b1 || data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL carry_lo got ack=%b data=%0h exp 1/ffffffff", ack, data); end
    addr = 3'd1;
    tick();
    checks++; if (ack !== 1'b1 || data !== 32'd0) begin failures++; $display("FAIL carry_hi got ack=%b data=%0h exp 1/0", ack, data); end
    addr = 3'd0;
    tick();
    checks++; if (data !== 32'd1) begin failures++; $display("FAIL carry_lo2 got=%0h exp=1", data); end
    addr = 3'd1;
    tick();
    checks++; if (data !== 32'd1) begin failures++; $display("FAIL carry_hi2 got=%0h exp=1", data); end
    req = 1'b0;
    tick();
    checks++; if (ack !== 1'b0 || data !== 32'd1) begin failures++; $display("FAIL carry_hold got ack=%b data=%0h exp 0/1", ack, data); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_saturation();
    logic k;
    logic [31:0] d;
    open_window();
    rv = 2'b11;
    tick();
    tick();
    force dut.instr_cnt = 33'h1_FFFF_FFFD;
    #1 release dut.instr_cnt;
    tick();
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL sat_exact got ovf=%b exp=0", ovf); end
    tick();
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL sat_over got ovf=%b exp=1", ovf); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    rv = 2'b00;
    rd(3'd2, k, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_lo got=%0h exp=ffffffff", d); end
    rd(3'd3, k, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL sat_hi got=%0h exp=1", d); end
    rd(3'd4, k, d);
    checks++; if (d !== 32'h16) begin failures++; $display("FAIL sat_status got=%0h exp=16", d); end
    open_window();
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL sat_start_clr got ovf=%b exp=0", ovf); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_clear();
    logic k;
    logic [31:0] d;
    open_window();
    for (int i = 0; i < 5; i++) begin
      rv = 2'b11;
      tick();
    end
    {clr, start, stop, req} = 4'b1111;
    addr = 3'd0;
    tick();
    {clr, start, stop, req} = 4'b0000;
    rv = 2'b00;
    checks++; if (ack !== 1'b1 || data !== 32'd5) begin failures++; $display("FAIL clr_preread got ack=%b data=%0d exp 1/5", ack, data); end
    checks++; if (st !== 2'd0) begin failures++; $display("FAIL clr_state got=%0d exp=0", st); end
    for (int a = 0; a < 5; a++) begin
      rd(3'(a), k, d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL clr_reg%0d got=%0h exp=0", a, d); end
    end
  endtask

  task automatic test_reset_mid();
    logic k;
    logic [31:0] d;
    open_window();
    for (int i = 0; i < 3; i++) begin
      rv = 2'b11;
      tick();
    end
    req = 1'b1;
    addr = 3'd2;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ack !== 1'b0 || data !== 32'd0) begin failures++; $display("FAIL rstmid_rd got ack=%b data=%0h exp 0/0", ack, data); end
    checks++; if (st !== 2'd0 || {done, tmo, ovf} !== 3'b000) begin failures++; $display("FAIL rstmid_state got st=%0d flags=%b exp 0/000", st, {done, tmo, ovf}); end
    req = 1'b0;
    rv = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    rd(3'd2, k, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL rstmid_instr got=%0d exp=0", d); end
  endtask

  task automatic test_random();
    logic k;
    logic [31:0] d;
    logic [31:0] expd;
    longint ec, ei;
    int len;
    bit doread;
    for (int w = 0; w < 15; w++) begin
      len = $urandom_range(1, 90);
      start = 1'b1;
      rv = 2'($urandom);
      tick();
      start = 1'b0;
      ec = 0;
      ei = 0;
      for (int c = 1; c <= len; c++) begin
        rv = 2'($urandom);
        stop = (c == len);
        doread = ($urandom_range(0, 3) == 0);
        req = doread;
        addr = $urandom_range(0, 1) ? 3'd2 : 3'd0;
        expd = (addr == 3'd0) ? 32'(ec) : 32'(ei);
        tick();
        ec = (ec + 1 > MAXV) ? MAXV : ec + 1;
        ei = (ei + $countones(rv) > MAXV) ? MAXV : ei + $countones(rv);
        if (doread) begin
          checks++; if (ack !== 1'b1 || data !== expd) begin failures++; $display("FAIL rand_mid w=%0d c=%0d got ack=%b data=%0d exp 1/%0d", w, c, ack, data, expd); end
        end
      end
      stop = 1'b0;
      req = 1'b0;
      rv = 2'b00;
      checks++; if (st !== 2'd2) begin failures++; $display("FAIL rand_state w=%0d got=%0d exp=2", w, st); end
      rd(3'd0, k, d);
      checks++; if (d !== 32'(ec)) begin failures++; $display("FAIL rand_cycles w=%0d got=%0d exp=%0d", w, d, ec); end
      rd(3'd2, k, d);
      checks++; if (d !== 32'(ei)) begin failures++; $display("FAIL rand_instr w=%0d got=%0d exp=%0d", w, d, ei); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lanes();
    test_restart();
    test_timeout();
    test_carry();
    test_saturation();
    test_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/retire_perf_mon.md
Name: retire_perf_mon

Overview:
- Synthesizable performance monitor for the dual-issue core.
- Counts cycles and retired instructions across NUM_LANES writeback lanes inside a measurement window opened by start_i and closed by stop_i, for example on a CSR-write detect.
- Includes a watchdog timeout, saturating counters and a coherent 32-bit register read port, so firmware and benches read CPI/IPC data without hierarchical probes.

Parameters:
NUM_LANES, 2, number of retire-valid lanes (1..4)
CNT_W, 48, width of cycle and instruction counters (33..64)
TIMEOUT, 200000, RUN cycles before watchdog fires; 0 disables the watchdog
TMO_W, 32, width of the watchdog counter; TIMEOUT must fit in TMO_W bits

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-low
retire_valid_i  in  NUM_LANES  one bit per lane; 1 = instruction retired this cycle
start_i  in  1  pulse: open a new measurement window
stop_i  in  1  pulse: close the window
clear_i  in  1  pulse: return to IDLE and zero everything
rd_req_i  in  1  read request, single cycle
rd_addr_i  in  3  register select
rd_ack_o  out  1  read response valid
rd_data_o  out  32  read data
state_o  out  2  0 IDLE, 1 RUN, 2 DONE, 3 TIMEOUT
done_o  out  1  high in DONE
timeout_o  out  1  high in TIMEOUT
overflow_o  out  1  sticky; set when either counter saturated

Behaviour:
- Reset (rst_i=0, async): state IDLE; counters, watchdog, shadow and overflow = 0; rd_ack_o=0, rd_data_o=0; done_o=timeout_o=0.
- IDLE: counters hold. start_i -> RUN, with counters and watchdog loaded with 0 on that edge.
- RUN, every cycle including the cycle stop_i is sampled:
  - cycle_cnt += 1.
  - instr_cnt += popcount(retire_valid_i), from 0 to NUM_LANES.
  - wdog += 1.
- The cycle in which start_i is sampled is not counted; its retirements are not counted.
- RUN transitions:
  - stop_i -> DONE.
  - Else if TIMEOUT != 0 and wdog == TIMEOUT-1 -> TIMEOUT. TIMEOUT=N therefore yields cycle_cnt = N on entry to TIMEOUT.
  - stop_i and watchdog expiry in the same cycle: DONE wins.
  - start_i in RUN: restart, zeroing counters; the current cycle is not counted.
- DONE/TIMEOUT: counters frozen. start_i -> RUN (restart, as from IDLE). stop_i ignored.
- clear_i has highest priority in every state: -> IDLE and zero counters, wdog, shadow and overflow. A read in the same cycle returns pre-clear values.
- Saturation: a counter whose next value would exceed 2^CNT_W-1 holds all-ones and sets overflow_o. overflow_o stays set until clear_i, start_i or reset.
- Read port:
  - rd_ack_o pulses exactly 1 cycle after each rd_req_i, with rd_data_o registered. Back-to-back requests give back-to-back acks.
  - rd_data_o holds its last value when rd_ack_o=0.
- Register map (rd_addr_i):
  - 0: cycle_cnt[31:0]; also latches cycle_cnt[CNT_W-1:32] into the cycle shadow.
  - 1: cycle shadow, zero-extended.
  - 2: instr_cnt[31:0]; also latches the instr high part into the instr shadow.
  - 3: instr shadow, zero-extended.
  - 4: status {27'b0, overflow, timeout, done, state[1:0]}.
  - 5: TIMEOUT[31:0].
  - 6,7: 0.
- Low-word reads take the value present in the request cycle, before that cycle's increment. The shadow makes a low-then-high read coherent while RUN.
- Reset asserted mid-RUN: immediate return to reset values; no partial window is retained.

Test Plan:
- Reset then start_i, 10 cycles with retire_valid_i=2'b11, stop_i on the 10th -> DONE. Status read = 0x06. Addr 0 = 10, addr 2 = 20.
- Alternating lane patterns 01,10,00,11 over 8 cycles then stop -> instr_cnt=8, cycle_cnt=8. A further 5 cycles of retirements leave the counts unchanged.
- TIMEOUT=100, start, no stop -> timeout_o rises after exactly 100 RUN cycles; cycle_cnt=100; state_o=3. Stop on cycle 100 instead -> DONE, timeout_o=0.
- CNT_W=33, counters preloaded near 2^33-1 (force or long run), retire 2/cycle -> instr_cnt pins at 0x1_FFFF_FFFF. overflow_o=1; addr 3 reads 0x1.
- During RUN, read addr 0 then addr 1 across a low-word carry (0xFFFFFFFF -> 0x0) -> the high word matches the low-word sample (0). Ack latency is 1 cycle each.
- clear_i asserted together with start_i and stop_i mid-RUN -> IDLE, all reads 0. Async rst_i pulse mid-RUN -> all outputs 0 immediately.
